// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter
// Purpose  : Round-robin arbiter that lets NREQ requesters take turns pushing
//            beats into one shared FIFO push port. A grant lasts at most
//            BURST beats, or less if the owner drops req_valid. Every grant is
//            followed by one IDLE cycle, where the next owner is chosen.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   [NREQ]        per-requester beat valid
//   req_data    in   [NREQ*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//   req_ready   out  [NREQ]        per-requester beat accepted
//   push_valid  out  beat valid toward FIFO push port
//   push_data   out  [WIDTH]       beat data toward FIFO
//   push_ready  in   FIFO can accept
//   grant_id    out  [clog2(NREQ)] current owner (meaningful while busy)
//   busy        out  high while a grant is active
// ============================================================================
module fifo_push_arbiter #(
  parameter int WIDTH = 19,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*WIDTH-1:0]      req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       push_valid,
  output logic [WIDTH-1:0]           push_data,
  input  logic                       push_ready,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            w_any;
  logic [GW-1:0]   w_pick;
  logic [GW-1:0]   w_next_ptr;
  logic [WIDTH-1:0] w_data [NREQ];

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_data[i] = req_data[i*WIDTH +: WIDTH];
    end
  endgenerate

  // First valid requester at or above ptr, wrapping past NREQ-1 to 0.
  always_comb begin
    int idx;
    idx    = 0;
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!w_any && req_valid[idx]) begin
        w_any  = 1'b1;
        w_pick = GW'(idx);
      end
    end
  end

  // Pointer moves to the requester just after the releasing owner.
  assign w_next_ptr = (g_q == GW'(NREQ - 1)) ? '0 : g_q + GW'(1);

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    push_valid = 1'b0;
    push_data  = '0;
    req_ready  = '0;

    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          g_d     = w_pick;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        push_valid     = req_valid[g_q];
        push_data      = w_data[g_q];
        req_ready[g_q] = push_ready;

        if (!req_valid[g_q]) begin
          // Owner has nothing more to send: release early.
          state_d = ST_IDLE;
          ptr_d   = w_next_ptr;
        end else if (push_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BURST - 1)) begin
            state_d = ST_IDLE;
            ptr_d   = w_next_ptr;
          end
        end
        // FIFO full with owner still valid: hold everything, no timeout.
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == ST_GRANT);
  assign grant_id = g_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_push_arbiter
// Purpose  : Self-checking bench for fifo_push_arbiter. Requesters present a
//            sequence of random data words; every issued word is queued per
//            requester, and a monitor pops and compares on each FIFO beat.
//            A grant-level reference model predicts busy/owner/handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_push_arbiter;

  localparam int WIDTH = 19;
  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int GW    = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  push_valid;
  logic [WIDTH-1:0]      push_data;
  logic                  push_ready;
  logic [GW-1:0]         grant_id;
  logic                  busy;

  fifo_push_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q [NREQ][$];   // words issued but not yet seen on FIFO
  logic [NREQ-1:0]  accepted;          // handshakes of the current cycle
  int               acc_cnt [NREQ];    // total words accepted per requester

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester i presents a fresh random word; it is expected on the FIFO later.
  task automatic new_item(input int i);
    logic [WIDTH-1:0] d;
    d = WIDTH'($urandom);
    exp_q[i].push_back(d);
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  // Stimulus-side bookkeeping: which requesters will see their word taken.
  always @(negedge clk) begin
    accepted = rst_n ? (req_valid & req_ready) : '0;
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic step(input logic [NREQ-1:0] v, input logic r);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (accepted[i]) begin
        acc_cnt[i]++;
        new_item(i);
      end
    end
    req_valid  = v;
    push_ready = r;
  endtask

  task automatic do_reset();
    step('0, 1'b0);
    rst_n = 1'b0;
    step('0, 1'b0);
    rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------------------
  // Monitor + grant-level reference model. The model tracks who owns the
  // FIFO and how many beats remain, and chooses owners round-robin.
  // ------------------------------------------------------------------------
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_left  = 0;

  always @(negedge clk) begin : p_mon
    logic [NREQ-1:0] e_rr;
    logic            e_pv;
    int              idx;
    bit              found;
    if (!rst_n) begin
      check("rst_push_valid", 64'(push_valid), 64'(0));
      check("rst_req_ready",  64'(req_ready),  64'(0));
      check("rst_busy",       64'(busy),       64'(0));
      check("rst_grant_id",   64'(grant_id),   64'(0));
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_left = 0;
    end else begin
      e_pv = m_busy ? req_valid[m_owner] : 1'b0;
      e_rr = (m_busy && push_ready) ? NREQ'(1) << m_owner : '0;
      check("busy",       64'(busy),       64'(m_busy));
      check("push_valid", 64'(push_valid), 64'(e_pv));
      check("req_ready",  64'(req_ready),  64'(e_rr));
      if (m_busy) check("grant_id", 64'(grant_id), 64'(m_owner));

      if (push_valid && push_ready && m_busy) begin
        if (exp_q[m_owner].size() == 0)
          check("beat_without_word", 64'(1), 64'(0));
        else
          check("push_data", 64'(push_data), 64'(exp_q[m_owner].pop_front()));
      end

      if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (!found && req_valid[idx]) begin
            found = 1'b1; m_owner = idx;
          end
        end
        if (found) begin m_busy = 1'b1; m_left = BURST; end
      end else if (!req_valid[m_owner]) begin
        m_busy = 1'b0; m_ptr = (m_owner + 1) % NREQ;
      end else if (push_ready) begin
        m_left--;
        if (m_left == 0) begin m_busy = 1'b0; m_ptr = (m_owner + 1) % NREQ; end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  initial begin
    int base [NREQ];
    logic [NREQ-1:0] rv;

    rst_n      = 1'b0;
    req_valid  = '0;
    push_ready = 1'b0;
    req_data   = '0;
    for (int i = 0; i < NREQ; i++) begin acc_cnt[i] = 0; new_item(i); end
    repeat (3) step('0, 1'b0);
    rst_n = 1'b1;
    step('0, 1'b0);

    // Single requester 2: 4 beats, 1 idle, 2 beats within 8 cycles.
    base[2] = acc_cnt[2];
    repeat (8) step(4'b0100, 1'b1);
    step('0, 1'b1);
    check("single_req_beats", 64'(acc_cnt[2] - base[2]), 64'(6));
    repeat (2) step('0, 1'b1);

    // All valid from ptr=0: grants 0,1,2,3,0 with BURST beats each.
    do_reset();
    for (int i = 0; i < NREQ; i++) base[i] = acc_cnt[i];
    repeat (5 * (BURST + 1)) step(4'b1111, 1'b1);
    step('0, 1'b1);
    check("rr_beats_req0", 64'(acc_cnt[0] - base[0]), 64'(2 * BURST));
    check("rr_beats_req1", 64'(acc_cnt[1] - base[1]), 64'(BURST));
    check("rr_beats_req3", 64'(acc_cnt[3] - base[3]), 64'(BURST));
    step('0, 1'b1);

    // Backpressure mid-burst on requester 1.
    do_reset();
    base[1] = acc_cnt[1];
    repeat (3) step(4'b0010, 1'b1);
    repeat (10) step(4'b0010, 1'b0);
    #1;
    check("stall_busy",      64'(busy),         64'(1));
    check("stall_grant_id",  64'(grant_id),     64'(1));
    check("stall_req_ready", 64'(req_ready[1]), 64'(0));
    check("stall_beats", 64'(acc_cnt[1] - base[1]), 64'(2));
    repeat (2) step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    check("stall_done_beats", 64'(acc_cnt[1] - base[1]), 64'(BURST));
    #1;
    check("stall_release", 64'(busy), 64'(0));
    step('0, 1'b1);

    // Early release by requester 3, then pending requester 0 wins.
    do_reset();
    repeat (3) step(4'b1000, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    #1;
    check("early_idle", 64'(busy), 64'(0));
    step(4'b0001, 1'b1);
    #1;
    check("early_next_busy", 64'(busy),     64'(1));
    check("early_next_gid",  64'(grant_id), 64'(0));
    repeat (BURST) step(4'b0001, 1'b1);
    step('0, 1'b1);

    // Reset during beat 2 of a grant; afterwards arbitration starts at 0.
    do_reset();
    base[2] = acc_cnt[2];
    repeat (3) step(4'b0100, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_push_valid", 64'(push_valid), 64'(0));
    check("rst_mid_req_ready",  64'(req_ready),  64'(0));
    check("rst_mid_busy",       64'(busy),       64'(0));
    step(4'b1010, 1'b1);
    rst_n = 1'b1;
    step(4'b1010, 1'b1);
    #1;
    check("rst_beat_dropped", 64'(acc_cnt[2] - base[2]), 64'(1));
    check("after_rst_gid",    64'(grant_id),             64'(1));
    check("after_rst_busy",   64'(busy),                 64'(1));
    step('0, 1'b1);
    step('0, 1'b1);

    // Random valid/ready traffic.
    rv = '0;
    for (int c = 0; c < 12000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(7) == 0) rv[i] = ~rv[i];
      step(rv, ($urandom_range(9) < 7));
    end
    step('0, 1'b0);
    step('0, 1'b0);

    // Only the word currently on offer may remain outstanding.
    for (int i = 0; i < NREQ; i++)
      check($sformatf("outstanding_req%0d", i), 64'(exp_q[i].size()), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
